// File: rtl/xs_video_pkg.sv
// Shared timing constants and helpers for the master video timing stage.
package xs_video_pkg;

  localparam int CNT_W        = 9;
  localparam int DEF_CLK_DIV  = 8;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_VIS    = 256;
  localparam int DEF_HS_START = 304;
  localparam int DEF_HS_END   = 336;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_V_VIS    = 240;
  localparam int DEF_VS_START = 248;
  localparam int DEF_VS_END   = 252;

  function automatic int half_div(input int clk_div);
    return clk_div / 2;
  endfunction

endpackage

// File: rtl/xs_video_timing_sync_pix_cen.sv
// Master-clock divider producing a square pixel enable, its rising-edge strobe
// and the internal tick that advances the raster counters.
module xs_pix_cen_gen
  import xs_video_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hold,
  output logic o_tick,
  output logic o_pix_cen,
  output logic o_pix_stb
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int HALF  = half_div(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_pix_cen;
  logic             r_pix_stb;
  logic             w_tick;

  assign w_tick     = (r_div == DIV_LAST) && !i_hold;
  assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div     <= DIV_LAST;
      r_pix_cen <= 1'b0;
      r_pix_stb <= 1'b0;
    end else if (i_hold) begin
      // Freeze the phase so release resumes exactly where it stopped.
      r_pix_stb <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_pix_cen <= (w_div_next < DIV_HALF);
      r_pix_stb <= w_tick;
    end
  end

  assign o_tick    = w_tick;
  assign o_pix_cen = r_pix_cen;
  assign o_pix_stb = r_pix_stb;

endmodule

// File: rtl/xs_video_timing_sync.sv
// Raster timing: H/V counters advanced by the pixel tick, with blank/sync
// decodes and line/frame strobes registered in step with the counters.
module xs_video_timing_sync
  import xs_video_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  output logic             o_pix_cen,
  output logic             o_pix_stb,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_line_stb,
  output logic             o_frame_stb
);

  localparam bit PARAMS_OK = (CLK_DIV >= 2) && (CLK_DIV % 2 == 0) &&
                             (H_TOTAL >= 1) && (H_TOTAL <= 512) &&
                             (V_TOTAL >= 1) && (V_TOTAL <= 512) &&
                             (H_VIS <= H_TOTAL) && (V_VIS <= V_TOTAL) &&
                             (HS_START < HS_END) && (VS_START < VS_END);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             w_tick;
  logic [CNT_W-1:0] r_h, r_v;
  logic [CNT_W-1:0] w_h_next, w_v_next;
  logic [CNT_W:0]   w_h_ext, w_v_ext;
  logic             r_hblank, r_vblank, r_hsync_n, r_vsync_n;
  logic             r_line_stb, r_frame_stb;

  xs_pix_cen_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_cen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_hold    (i_hold),
    .o_tick    (w_tick),
    .o_pix_cen (o_pix_cen),
    .o_pix_stb (o_pix_stb)
  );

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_tick) begin
      if (r_h == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h_next = r_h + 1'b1;
      end
    end
  end

  // One extra bit so a boundary of 512 still compares correctly.
  assign w_h_ext = {1'b0, w_h_next};
  assign w_v_ext = {1'b0, w_v_next};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h         <= H_LAST;
      r_v         <= V_LAST;
      r_hblank    <= 1'b1;
      r_vblank    <= 1'b1;
      r_hsync_n   <= 1'b1;
      r_vsync_n   <= 1'b1;
      r_line_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
    end else if (i_hold) begin
      r_line_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
    end else begin
      r_h         <= w_h_next;
      r_v         <= w_v_next;
      r_hblank    <= (w_h_ext >= (CNT_W+1)'(H_VIS));
      r_vblank    <= (w_v_ext >= (CNT_W+1)'(V_VIS));
      r_hsync_n   <= !((w_h_ext >= (CNT_W+1)'(HS_START)) && (w_h_ext < (CNT_W+1)'(HS_END)));
      r_vsync_n   <= !((w_v_ext >= (CNT_W+1)'(VS_START)) && (w_v_ext < (CNT_W+1)'(VS_END)));
      r_line_stb  <= w_tick && (w_h_next == '0);
      r_frame_stb <= w_tick && (w_h_next == '0) && (w_v_next == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    assert (PARAMS_OK)
      else $error("xs_video_timing_sync: illegal timing parameters");
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_hblank    = r_hblank;
  assign o_vblank    = r_vblank;
  assign o_hsync_n   = r_hsync_n;
  assign o_vsync_n   = r_vsync_n;
  assign o_line_stb  = r_line_stb;
  assign o_frame_stb = r_frame_stb;

endmodule

// File: tb/tb_xs_video_timing_sync.sv
// Bench for xs_video_timing_sync: two small-raster instances (CLK_DIV 4 and 2)
// checked every cycle against an arithmetic raster model plus literal checks.
module tb_xs_video_timing_sync;

  localparam int D1 = 4, D2 = 2;
  localparam int HT = 8, HV = 6, HSS = 6, HSE = 7;
  localparam int VT = 4, VV = 3, VSS = 3, VSE = 4;

  typedef struct {
    int h, v, cen, stb, ls, fs, hb, vb, hs_n, vs_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, hold1, rst2, hold2;
  logic cen1, stb1, hb1, vb1, hsn1, vsn1, ls1, fs1;
  logic cen2, stb2, hb2, vb2, hsn2, vsn2, ls2, fs2;
  logic [8:0] h1, v1, h2, v2;

  int n_checks = 0;
  int n_fail   = 0;

  xs_video_timing_sync #(
    .CLK_DIV(D1), .H_TOTAL(HT), .H_VIS(HV), .HS_START(HSS), .HS_END(HSE),
    .V_TOTAL(VT), .V_VIS(VV), .VS_START(VSS), .VS_END(VSE)
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_hold(hold1),
    .o_pix_cen(cen1), .o_pix_stb(stb1), .o_h(h1), .o_v(v1),
    .o_hblank(hb1), .o_vblank(vb1), .o_hsync_n(hsn1), .o_vsync_n(vsn1),
    .o_line_stb(ls1), .o_frame_stb(fs1)
  );

  xs_video_timing_sync #(
    .CLK_DIV(D2), .H_TOTAL(HT), .H_VIS(HV), .HS_START(HSS), .HS_END(HSE),
    .V_TOTAL(VT), .V_VIS(VV), .VS_START(VSS), .VS_END(VSE)
  ) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_hold(hold2),
    .o_pix_cen(cen2), .o_pix_stb(stb2), .o_h(h2), .o_v(v2),
    .o_hblank(hb2), .o_vblank(vb2), .o_hsync_n(hsn2), .o_vsync_n(vsn2),
    .o_line_stb(ls2), .o_frame_stb(fs2)
  );

  // Model state: a = clocks advanced (not held) since the last reset clock.
  int a1 = 0, a2 = 0;
  bit adv1 = 0, adv2 = 0, valid1 = 0, valid2 = 0;

  always @(posedge clk) begin
    if (rst1) begin a1 <= 0; adv1 <= 0; valid1 <= 1; end
    else if (hold1) adv1 <= 0;
    else begin a1 <= a1 + 1; adv1 <= 1; end
    if (rst2) begin a2 <= 0; adv2 <= 0; valid2 <= 1; end
    else if (hold2) adv2 <= 0;
    else begin a2 <= a2 + 1; adv2 <= 1; end
  end

  function automatic int div_of(input int a, input int d);
    return (d - 1 + a) % d;
  endfunction

  function automatic exp_t model(input int a, input bit adv, input int d);
    exp_t e;
    int ticks, hp, dv;
    dv    = div_of(a, d);
    ticks = (a + d - 1) / d;
    hp    = HT - 1 + ticks;
    e.h   = hp % HT;
    e.v   = (VT - 1 + hp / HT) % VT;
    e.cen = (a > 0 && dv < d / 2) ? 1 : 0;
    e.stb = (adv && dv == 0) ? 1 : 0;
    e.ls  = (e.stb == 1 && e.h == 0) ? 1 : 0;
    e.fs  = (e.ls == 1 && e.v == 0) ? 1 : 0;
    if (a == 0) begin
      e.hb = 1; e.vb = 1; e.hs_n = 1; e.vs_n = 1;
    end else begin
      e.hb   = (e.h >= HV) ? 1 : 0;
      e.vb   = (e.v >= VV) ? 1 : 0;
      e.hs_n = (e.h >= HSS && e.h < HSE) ? 0 : 1;
      e.vs_n = (e.v >= VSS && e.v < VSE) ? 0 : 1;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      e = model(a1, adv1, D1);
      check("d1.h", int'(h1), e.h);       check("d1.v", int'(v1), e.v);
      check("d1.cen", int'(cen1), e.cen); check("d1.pix_stb", int'(stb1), e.stb);
      check("d1.line_stb", int'(ls1), e.ls); check("d1.frame_stb", int'(fs1), e.fs);
      check("d1.hblank", int'(hb1), e.hb); check("d1.vblank", int'(vb1), e.vb);
      check("d1.hsync_n", int'(hsn1), e.hs_n); check("d1.vsync_n", int'(vsn1), e.vs_n);
    end
    if (valid2) begin
      e = model(a2, adv2, D2);
      check("d2.h", int'(h2), e.h);       check("d2.v", int'(v2), e.v);
      check("d2.cen", int'(cen2), e.cen); check("d2.pix_stb", int'(stb2), e.stb);
      check("d2.line_stb", int'(ls2), e.ls); check("d2.frame_stb", int'(fs2), e.fs);
      check("d2.hblank", int'(hb2), e.hb); check("d2.vblank", int'(vb2), e.vb);
      check("d2.hsync_n", int'(hsn2), e.hs_n); check("d2.vsync_n", int'(vsn2), e.vs_n);
    end
  end

  // Downstream edge-detecting latch fed by dut1's H.
  bit   lat_en = 0;
  logic lat_prev = 1'b0;
  int   lat_q[$];
  always @(posedge clk) begin
    if (lat_en && cen1 && !lat_prev) lat_q.push_back(int'(h1));
    lat_prev <= cen1;
  end

  initial begin
    int nl, nf, cnt, held_cen, wait_n;
    bit found;
    exp_t e;
    rst1 = 1; hold1 = 0; rst2 = 1; hold2 = 1;
    repeat (3) @(negedge clk);
    check("rst.h", int'(h1), 7);     check("rst.v", int'(v1), 3);
    check("rst.cen", int'(cen1), 0); check("rst.vsync_n", int'(vsn1), 1);
    check("rst_hold.h", int'(h2), 7); check("rst_hold.cen", int'(cen2), 0);

    // Release dut1; clock 1 is the first tick.
    rst1 = 0; lat_en = 1;
    @(negedge clk);
    check("first.h", int'(h1), 0);    check("first.v", int'(v1), 0);
    check("first.cen", int'(cen1), 1); check("first.pix_stb", int'(stb1), 1);
    check("first.line_stb", int'(ls1), 1); check("first.frame_stb", int'(fs1), 1);
    check("first.hblank", int'(hb1), 0);   check("first.vblank", int'(vb1), 0);
    nl = 1; nf = 1;
    for (int k = 2; k <= 129; k++) begin
      @(negedge clk);
      if (k <= 8) check("cen_pattern", int'(cen1), (((k - 1) % 4) < 2) ? 1 : 0);
      if (ls1) nl++;
      if (fs1) nf++;
    end
    check("line_count", nl, 5);
    check("frame_count", nf, 2);
    lat_en = 0;
    check("latch_updates", lat_q.size(), 32);
    for (int i = 0; i < lat_q.size(); i++) check("latch_q", lat_q[i], i % 8);

    // Hold at H=3, div=1.
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      e = model(a1, adv1, D1);
      if (e.h == 3 && div_of(a1, D1) == 1) found = 1;
      else @(negedge clk);
    end
    check("hold_reach", int'(found), 1);
    held_cen = int'(cen1);
    hold1 = 1;
    repeat (10) begin
      @(negedge clk);
      check("hold.h", int'(h1), 3);
      check("hold.cen", int'(cen1), held_cen);
      check("hold.strobes", int'(stb1 | ls1 | fs1), 0);
    end
    hold1 = 0;
    cnt = 0; wait_n = 0;
    while (cnt == 0 && wait_n < 16) begin
      @(negedge clk); wait_n++;
      if (stb1) cnt = wait_n;
    end
    check("hold_release_latency", cnt, 3);

    // Reset pulse mid-frame at H=5, V=2.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      e = model(a1, adv1, D1);
      if (e.h == 5 && e.v == 2) found = 1;
      else @(negedge clk);
    end
    check("rst_reach", int'(found), 1);
    rst1 = 1;
    @(negedge clk);
    check("midrst.h", int'(h1), 7);      check("midrst.v", int'(v1), 3);
    check("midrst.hblank", int'(hb1), 1); check("midrst.vblank", int'(vb1), 1);
    check("midrst.hsync_n", int'(hsn1), 1); check("midrst.vsync_n", int'(vsn1), 1);
    check("midrst.strobes", int'(stb1 | ls1 | fs1), 0);
    rst1 = 0;

    // CLK_DIV=2 instance: drop reset and hold together.
    rst2 = 0; hold2 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("div2.cen", int'(cen2), k % 2);
      check("div2.h", int'(h2), (k - 1) / 2);
    end

    // Randomised hold pattern on both instances.
    for (int i = 0; i < 400; i++) begin
      hold1 = ($urandom_range(0, 3) == 0);
      hold2 = ($urandom_range(0, 4) == 0);
      rst1  = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst1 = 0; hold1 = 0; hold2 = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
